// File: rtl/dmem_line_responder.sv
// Line-granular data memory responder: accepts one 256-bit line read or write,
// then acknowledges it a fixed LATENCY cycles after acceptance.
module dmem_line_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [7:0]  COUNT_LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t                  state;
    logic [7:0]              count;
    logic [DEPTH_LOG2-1:0]   line_q;
    logic [255:0]            wdata_q;
    logic                    write_q;
    logic                    commit;

    logic [255:0] mem [DEPTH];

    // Offset bits and upper bits are deliberately ignored (upper bits alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[4:0], addr_i[31:DEPTH_LOG2+5]};

    // The request completes on the edge that moves WAIT into ACK.
    assign commit = (state == WAIT) && enable_i && (count == 8'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            count   <= 8'd0;
            ack_o   <= 1'b0;
            data_o  <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        line_q  <= addr_i[DEPTH_LOG2+4:5];
                        wdata_q <= data_i;
                        write_q <= write_i;
                        count   <= COUNT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable_i) begin
                        // Initiator withdrew: drop silently, nothing committed.
                        state <= IDLE;
                    end else if (count == 8'd0) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                        if (!write_q) begin
                            data_o <= mem[line_q];
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                ACK: begin
                    // No acceptance here; the held enable is seen next in IDLE.
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: line storage has no reset; clearing a RAM array is not
    // implementable in block memory, and its contents survive reset by design.
    always_ff @(posedge clk_i) begin
        if (commit && write_q) begin
            mem[line_q] <= wdata_q;
        end
    end

endmodule

// File: doc/dmem_line_responder.md
DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10, giving the cycles from request acceptance to the acknowledge edge; legal range 2..255.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, giving the log2 of the number of 256-bit lines (512 lines, 16 KiB).
REQ-003 SHALL have port clk_i, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port addr_i, input, 32 bits: byte address of the line; bits [DEPTH_LOG2+4:5] select the line; bits [4:0] and the upper bits are ignored (upper-bit aliasing is intended).
REQ-006 SHALL have port data_i, input, 256 bits: write line data.
REQ-007 SHALL have port enable_i, input, 1 bit: request valid, held high by the initiator until the acknowledge.
REQ-008 SHALL have port write_i, input, 1 bit: 1 = line write, 0 = line read.
REQ-009 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256 bits: registered read line data.

Function
REQ-011 SHALL implement a state machine with states IDLE, WAIT and ACK, plus an 8-bit down-counter.
REQ-012 In IDLE, at an edge T0 with enable_i=1, SHALL latch addr_i, data_i and write_i, load the counter with LATENCY-2, and enter WAIT; with enable_i=0 it SHALL stay in IDLE.
REQ-013 In WAIT with enable_i=1 and counter>0, SHALL decrement the counter each edge.
REQ-014 In WAIT with enable_i=1 and counter=0, SHALL at that edge (T0+LATENCY-1) enter ACK, set ack_o=1, and then:
  - on a read, load data_o from the latched line;
  - on a write, store the latched data into the latched line.
REQ-015 ack_o SHALL be high for exactly one cycle, so the initiator samples it at edge T0+LATENCY.
REQ-016 ACK SHALL always go to IDLE with ack_o=0; no request is accepted at the edge leaving ACK.
REQ-017 In WAIT, sampling enable_i=0 SHALL abort the request:
  - return to IDLE;
  - no ack, no memory write, data_o unchanged.
  This discards the redundant request the initiator raises while it holds enable_i one cycle past the acknowledge.
REQ-018 Changes on addr_i, data_i or write_i after T0 SHALL have no effect on the in-flight request.
REQ-019 data_o SHALL hold its value between read acknowledges; a write acknowledge SHALL NOT alter data_o.
REQ-020 A read of a line in the same cycle as a write completion to it SHALL NOT occur, since requests are serialised; a read issued after a write acknowledge SHALL return the new data.
REQ-021 A write-then-read sequence (dirty writeback followed by refill) with enable_i held continuously high SHALL be accepted at the edge after the writeback's ACK-to-IDLE transition, using the address and write_i present then.

Reset
REQ-022 While rst_i=0, state SHALL be IDLE, counter=0, ack_o=0 and data_o=256'h0, asynchronously.
REQ-023 Reset asserted mid-request SHALL discard the request:
  - no ack after release;
  - an uncommitted write SHALL NOT reach memory.
REQ-024 Line storage SHALL NOT be cleared by reset; its initial contents are undefined unless preloaded by the bench.

Verification
REQ-025 Read latency: preload line 3 with pattern A; enable_i=1, write_i=0, addr_i=32'h60 accepted at T0 -> ack_o high only between T0+9 and T0+10; data_o=A at T0+10 sample.
REQ-026 Write then read: write 256'h...DEADBEEF to addr 32'h2000_0040 (line 2), then read addr 32'h40 -> second ack returns the written value, demonstrating aliasing of upper address bits.
REQ-027 Writeback/refill chain: enable_i held high, write_i=1 addr 32'h80 until ack, then write_i=0 addr 32'h1080 next cycle -> two acks 11 cycles apart (ACK plus LATENCY); line 4 holds the write data; data_o equals line 132's content.
REQ-028 Trailing enable: after a read ack, enable_i stays high one extra cycle then drops -> no second ack within 3*LATENCY cycles; data_o unchanged.
REQ-029 Reset mid-write: pulse rst_i low at T0+5 of a write to line 7 -> ack_o never rises; line 7 retains its old content; data_o=0.
REQ-030 Parameter sweep: LATENCY=2 -> ack sampled at T0+2; LATENCY=255 -> ack sampled at T0+255; address bits [4:0] varied -> same line accessed.
